dm_store_unit: RTL and testbench
================================

// Module: dm_store_unit
// PURPOSE
//  Store-side counterpart of the MEM-stage load byte-select path. Turns SW/SH/SB into an aligned
//  word write with byte enables, raises AdES, and queues accepted stores in a small FIFO.
//  The FIFO drains to the DM/timer bridge over a req/ack handshake.
//  Sits between the MEM pipeline register and the bridge; stalls the pipe when the queue is full.
// PARAMETERS
//  DEPTH    2   store-queue entries; power of two, >=1
//  ADDR_W   32  address width carried on the bus
// PORTS
//  clk        in   1   clock
//  reset      in   1   asynchronous, active-low reset
//  StType     in   2   00 NOSTORE, 01 SW, 10 SH, 11 SB
//  Addr       in   32  effective address from ALU
//  WrData     in   32  rt value, unaligned
//  DMOv       in   1   address-calc overflow from ALU
//  Flush      in   1   exception/eret kill of the MEM-stage instruction
//  LdAddr     in   32  address of the concurrent MEM-stage load
//  LdValid    in   1   a load is in MEM this cycle
//  AdES       out  1   store address exception (combinational)
//  Stall      out  1   freeze IF..MEM this cycle
//  BusReq     out  1   head entry valid, presented to bridge
//  BusAddr    out  32  word address {Addr[31:2],2'b00} of head entry
//  BusBE      out  4   byte enables of head entry
//  BusWData   out  32  lane-aligned data of head entry
//  BusAck     in   1   bridge accepted head entry this cycle
// BEHAVIOUR
//  Alignment and enables, combinational on inputs:
//   SW: BE=1111, data=WrData. SH: BE=0011 or 1100 by Addr[1], data={2{WrData[15:0]}}.
//   SB: BE=0001<<Addr[1:0], data={4{WrData[7:0]}}.
//  AdES=StType!=0 and any of the following:
//   SW with Addr[1:0]!=0; SH with Addr[0]=1;
//   Addr outside DM 0x0000-0x2FFF, TC0 0x7F00-0x7F0B and TC1 0x7F10-0x7F1B;
//   SH/SB to any timer address; any store to timer COUNT (offset 8); DMOv.
//  AdES asserts regardless of Flush, Stall or queue state.
//  accept = StType!=0 & ~AdES & ~Flush & ~Stall. An accepted store is written at the tail on the next edge.
//  Queue: count 0..DEPTH, head/tail pointers wrap modulo DEPTH. BusReq=(count!=0).
//   Bus* outputs come straight from the head entry and are stable while BusReq & ~BusAck.
//  Pop: on BusReq & BusAck at the edge, head advances and count decrements.
//   BusAck while BusReq=0 is ignored.
//  Simultaneous accept and pop: count is unchanged, both pointers advance. Accept into a full
//   queue is legal in the same cycle as a pop.
//  Stall = (StType!=0 & ~AdES & ~Flush & count==DEPTH & ~BusAck)
//        | (LdValid & hit), where hit means any valid entry has word address == LdAddr[31:2].
//   The load waits until the matching store drains. There is no forwarding.
//  Flush never removes queued entries; stores already queued have committed and must drain.
//  Reset (reset=0, async): count=0, pointers=0, BusReq=0, BusBE=0, BusAddr=0, BusWData=0, Stall=0.
//   Entry storage needs no reset. Reset mid-handshake drops all entries; the bridge must ignore the aborted req.
//  Latency: an accepted store reaches BusReq 1 cycle later with an empty queue; ack drains 1 entry/cycle.
// STRUCTURE
//  Shared macro header gets the StType encodings (NOSTORE/SW/SH/SB), MIN/MAX_DM, MIN/MAX_TC0,
//   MIN/MAX_TC1 and TC_COUNT_OFF. The load path uses the same range constants.
//  Sub-module st_align: pure combinational BE/data/AdES generation.
//  Top: queue storage, pointers, count, hazard compare, stall.
// TESTING
//  SB Addr=0x0000_0013 WrData=0xAB -> next cycle BusReq=1 BusAddr=0x10 BE=1000 BusWData=0xABABABAB.
//  SH Addr=0x0000_0005 -> AdES=1, no enqueue. SW Addr=0x7F08 -> AdES=1. SB Addr=0x7F04 -> AdES=1.
//  SW Addr=0x3000 -> AdES=1. SW Addr=0x7F04 -> AdES=0, BE=1111.
//  DEPTH=2, BusAck=0: three back-to-back SW -> third cycle Stall=1.
//   Pulse BusAck -> third accepted in that cycle, count stays 2.
//  SW 0x20 queued, BusAck=0, then LdValid=1 LdAddr=0x22 -> Stall=1 until ack, then Stall=0.
//  Store with Flush=1 -> no enqueue. reset=0 with 2 entries pending -> BusReq=0 immediately, without a clock edge.

Source files
------------

// File: rtl/dm_store_unit_pkg.sv
// dm_store_unit_pkg: store-type encodings and DM/timer address map shared by the MEM-stage load/store paths
package dm_store_unit_pkg;
  typedef enum logic [1:0] {ST_NOSTORE = 2'b00, ST_SW = 2'b01, ST_SH = 2'b10, ST_SB = 2'b11} st_type_e;
  localparam logic [31:0] MIN_DM       = 32'h0000_0000;
  localparam logic [31:0] MAX_DM       = 32'h0000_2FFF;
  localparam logic [31:0] MIN_TC0      = 32'h0000_7F00;
  localparam logic [31:0] MAX_TC0      = 32'h0000_7F0B;
  localparam logic [31:0] MIN_TC1      = 32'h0000_7F10;
  localparam logic [31:0] MAX_TC1      = 32'h0000_7F1B;
  localparam logic [31:0] TC_COUNT_OFF = 32'h0000_0008;
endpackage

// File: rtl/dm_store_unit_st_align.sv
// dm_store_unit_st_align: combinational byte enables, lane replication and store address exception
module dm_store_unit_st_align
  import dm_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [1:0]        st_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wr_data,
  input  logic              dm_ov,
  output logic [3:0]        be,
  output logic [31:0]       wdata,
  output logic              ades
);
  logic in_dm, in_tc, misalign;
  // Lane placement and legality check; MIN_DM is zero so only the upper DM bound needs comparing
  always_comb begin
    be = st_type == ST_SW ? 4'hF : st_type == ST_SH ? (addr[1] ? 4'hC : 4'h3) :
         st_type == ST_SB ? 4'b0001 << addr[1:0] : 4'h0;
    wdata = st_type == ST_SH ? {2{wr_data[15:0]}} : st_type == ST_SB ? {4{wr_data[7:0]}} : wr_data;
    in_dm = addr <= ADDR_W'(MAX_DM);
    in_tc = (addr >= ADDR_W'(MIN_TC0) && addr <= ADDR_W'(MAX_TC0)) ||
            (addr >= ADDR_W'(MIN_TC1) && addr <= ADDR_W'(MAX_TC1));
    misalign = (st_type == ST_SW && addr[1:0] != 2'b00) || (st_type == ST_SH && addr[0]);
    ades = st_type != ST_NOSTORE && (misalign || dm_ov || !(in_dm || in_tc) ||
           (in_tc && (st_type != ST_SW || addr[3:2] == TC_COUNT_OFF[3:2])));
  end
endmodule

// File: rtl/dm_store_unit.sv
// dm_store_unit: aligns MEM-stage stores and queues them for the DM/timer bridge, stalling on full queue or load hazard
module dm_store_unit
  import dm_store_unit_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        StType,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WrData,
  input  logic              DMOv,
  input  logic              Flush,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic              LdValid,
  output logic              AdES,
  output logic              Stall,
  output logic              BusReq,
  output logic [ADDR_W-1:0] BusAddr,
  output logic [3:0]        BusBE,
  output logic [31:0]       BusWData,
  input  logic              BusAck
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [ADDR_W-3:0] q_addr [DEPTH];
  logic [3:0]        q_be   [DEPTH];
  logic [31:0]       q_data [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              hit, store, accept, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  dm_store_unit_st_align #(.ADDR_W(ADDR_W)) u_align (
    .st_type(StType),
    .addr   (Addr),
    .wr_data(WrData),
    .dm_ov  (DMOv),
    .be     (be),
    .wdata  (wdata),
    .ades   (AdES)
  );
  // A pending load must wait while any queued store targets the same word
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      hit = hit | (vld[i] && (LdAddr & ~ADDR_W'(3)) == {q_addr[i], 2'b00});
  end
  assign store    = StType != ST_NOSTORE && !AdES && !Flush;
  assign Stall    = (store && count == CW'(DEPTH) && !BusAck) || (LdValid && hit);
  assign accept   = store && !Stall;
  assign pop      = BusReq && BusAck;
  assign BusReq   = count != '0;
  assign BusAddr  = BusReq ? {q_addr[head], 2'b00} : '0;
  assign BusBE    = BusReq ? q_be[head] : '0;
  assign BusWData = BusReq ? q_data[head] : '0;
  // Queue bookkeeping; on a full-queue accept+pop the head slot is cleared then refilled at the same index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
      vld   <= '0;
    end else begin
      count <= count + CW'(accept) - CW'(pop);
      if (pop) begin
        head      <= nxt(head);
        vld[head] <= 1'b0;
      end
      if (accept) begin
        tail      <= nxt(tail);
        vld[tail] <= 1'b1;
      end
    end
  end
  // Entry payload; validity is tracked separately so storage needs no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      q_addr[tail] <= Addr[ADDR_W-1:2];
      q_be[tail]   <= be;
      q_data[tail] <= wdata;
    end
  end
endmodule

// File: tb/tb_dm_store_unit.sv
// tb_dm_store_unit: directed self-checking bench for the store alignment, queue and hazard stall
module tb_dm_store_unit;
  logic        clk = 1'b0, reset = 1'b0;
  logic [1:0]  StType = 2'b00;
  logic [31:0] Addr = '0, WrData = '0, LdAddr = '0, BusAddr, BusWData;
  logic        DMOv = 1'b0, Flush = 1'b0, LdValid = 1'b0, BusAck = 1'b0;
  logic        AdES, Stall, BusReq;
  logic [3:0]  BusBE;
  int checks = 0, errors = 0;
  logic [1:0]  vst [9] = '{2'd2, 2'd1, 2'd3, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1};
  logic [31:0] va  [9] = '{32'h5, 32'h7F08, 32'h7F04, 32'h3000, 32'h7F04, 32'h7F1C, 32'h2, 32'h100, 32'h7F18};
  logic        vov [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        vexp[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  dm_store_unit dut (
    .clk(clk), .reset(reset), .StType(StType), .Addr(Addr), .WrData(WrData), .DMOv(DMOv),
    .Flush(Flush), .LdAddr(LdAddr), .LdValid(LdValid), .AdES(AdES), .Stall(Stall),
    .BusReq(BusReq), .BusAddr(BusAddr), .BusBE(BusBE), .BusWData(BusWData), .BusAck(BusAck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv(input logic [1:0] st, input logic [31:0] a, input logic [31:0] d);
    StType = st;
    Addr   = a;
    WrData = d;
  endtask

  initial begin
    #1;
    chk("rst_req", BusReq, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_addr", BusAddr, 0);
    chk("rst_be", BusBE, 0);
    chk("rst_wdata", BusWData, 0);
    @(negedge clk);
    reset = 1'b1;
    drv(2'd3, 32'h13, 32'hAB);
    #1 chk("sb_ades", AdES, 0);
    tick;
    drv(2'd0, 0, 0);
    #1;
    chk("sb_req", BusReq, 1);
    chk("sb_addr", BusAddr, 32'h10);
    chk("sb_be", BusBE, 4'b1000);
    chk("sb_wdata", BusWData, 32'hABABABAB);
    BusAck = 1'b1;
    tick;
    BusAck = 1'b0;
    #1 chk("sb_pop", BusReq, 0);
    for (int i = 0; i < 9; i++) begin
      drv(vst[i], va[i], 32'h0);
      DMOv = vov[i];
      #1 chk("ades", AdES, vexp[i]);
      if (!vexp[i]) drv(2'd0, 0, 0);
      tick;
      #1 chk("ades_noenq", BusReq, 0);
      drv(2'd0, 0, 0);
      DMOv = 1'b0;
    end
    drv(2'd1, 32'h7F04, 32'h11223344);
    #1 chk("sw_tc_ades", AdES, 0);
    tick;
    drv(2'd0, 0, 0);
    #1;
    chk("sw_tc_be", BusBE, 4'hF);
    chk("sw_tc_addr", BusAddr, 32'h7F04);
    chk("sw_tc_wdata", BusWData, 32'h11223344);
    BusAck = 1'b1;
    tick;
    BusAck = 1'b0;
    drv(2'd2, 32'h2, 32'h55667788);
    tick;
    drv(2'd0, 0, 0);
    #1;
    chk("sh_be", BusBE, 4'hC);
    chk("sh_addr", BusAddr, 32'h0);
    chk("sh_wdata", BusWData, 32'h77887788);
    BusAck = 1'b1;
    tick;
    BusAck = 1'b0;
    drv(2'd1, 32'h100, 32'hA0);
    #1 chk("full_s0", Stall, 0);
    tick;
    drv(2'd1, 32'h104, 32'hA1);
    #1 chk("full_s1", Stall, 0);
    tick;
    drv(2'd1, 32'h108, 32'hA2);
    #1 chk("full_s2", Stall, 1);
    chk("full_head", BusAddr, 32'h100);
    BusAck = 1'b1;
    #1 chk("full_ack_stall", Stall, 0);
    tick;
    BusAck = 1'b0;
    drv(2'd1, 32'h10C, 32'hA3);
    #1 chk("full_still", Stall, 1);
    chk("full_head2", BusAddr, 32'h104);
    drv(2'd0, 0, 0);
    BusAck = 1'b1;
    tick;
    #1;
    chk("full_head3", BusAddr, 32'h108);
    chk("full_data3", BusWData, 32'hA2);
    tick;
    BusAck = 1'b0;
    #1 chk("full_empty", BusReq, 0);
    drv(2'd1, 32'h20, 32'h0);
    tick;
    drv(2'd0, 0, 0);
    LdValid = 1'b1;
    LdAddr  = 32'h24;
    #1 chk("ld_miss", Stall, 0);
    LdAddr = 32'h22;
    #1 chk("ld_hit", Stall, 1);
    tick;
    #1 chk("ld_hold", Stall, 1);
    BusAck = 1'b1;
    #1 chk("ld_ack_cycle", Stall, 1);
    tick;
    BusAck = 1'b0;
    #1 chk("ld_release", Stall, 0);
    chk("ld_drained", BusReq, 0);
    LdValid = 1'b0;
    drv(2'd1, 32'h40, 32'h0);
    Flush = 1'b1;
    #1 chk("flush_ades", AdES, 0);
    chk("flush_stall", Stall, 0);
    tick;
    drv(2'd2, 32'h5, 32'h0);
    #1 chk("flush_ades_sh", AdES, 1);
    drv(2'd0, 0, 0);
    Flush = 1'b0;
    #1 chk("flush_noenq", BusReq, 0);
    tick;
    drv(2'd1, 32'h200, 32'h1);
    tick;
    drv(2'd1, 32'h204, 32'h2);
    tick;
    drv(2'd0, 0, 0);
    #1 chk("pre_rst_req", BusReq, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_req", BusReq, 0);
    chk("async_rst_addr", BusAddr, 0);
    chk("async_rst_stall", Stall, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("post_rst_req", BusReq, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
